// File: rtl/fifo_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fifo_ram_ctrl
// Purpose  : FIFO controller around an external simple dual-port RAM.
//            Port A writes, port B reads with one cycle of registered latency,
//            and a single-word output stage presents the oldest word.
//            DEPTH must equal 2**LG_DEPTH so that the pointers wrap naturally.
// Revision : 1.0  initial release
// ============================================================================
module fifo_ram_ctrl #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 64,
    parameter int LG_DEPTH = 6
) (
    input  logic                clk,
    input  logic                rst,
    // upstream
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    in_data,
    // downstream
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    out_data,
    // RAM port A (write only)
    output logic                ram_ena,
    output logic                ram_wea,
    output logic [LG_DEPTH-1:0] ram_addra,
    output logic [WIDTH-1:0]    ram_dina,
    // RAM port B (read only)
    output logic                ram_enb,
    output logic                ram_web,
    output logic [LG_DEPTH-1:0] ram_addrb,
    input  logic [WIDTH-1:0]    ram_doutb,
    // occupancy
    output logic [LG_DEPTH:0]   count
);

    localparam logic [LG_DEPTH:0] c_depth = (LG_DEPTH+1)'(DEPTH);

    typedef enum logic [0:0] {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t              r_state;
    logic [LG_DEPTH-1:0] r_wr_ptr;
    logic [LG_DEPTH-1:0] r_rd_ptr;
    logic [LG_DEPTH:0]   r_mem_count;

    logic w_push;
    logic w_pop;
    logic w_fetch;

    // Handshake decode; rst gates push/fetch so the RAM is idle during reset.
    assign in_ready  = (r_mem_count < c_depth);
    assign out_valid = (r_state == S_FULL);
    assign w_push    = in_valid && in_ready && !rst;
    assign w_pop     = out_valid && out_ready;
    // Fetch only when the output stage is free or being drained this cycle,
    // so the RAM's registered read never overwrites an unconsumed word.
    assign w_fetch   = (r_mem_count != '0) && (!out_valid || out_ready) && !rst;

    assign ram_ena   = w_push;
    assign ram_wea   = w_push;
    assign ram_addra = r_wr_ptr;
    assign ram_dina  = in_data;

    assign ram_enb   = w_fetch;
    assign ram_web   = 1'b0;
    assign ram_addrb = r_rd_ptr;

    // The output stage is the RAM read register itself.
    assign out_data  = ram_doutb;
    assign count     = r_mem_count + {{LG_DEPTH{1'b0}}, out_valid};

    // Pointers and RAM occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_mem_count <= '0;
        end else begin
            if (w_push)  r_wr_ptr <= r_wr_ptr + LG_DEPTH'(1);
            if (w_fetch) r_rd_ptr <= r_rd_ptr + LG_DEPTH'(1);
            case ({w_push, w_fetch})
                2'b10:   r_mem_count <= r_mem_count + (LG_DEPTH+1)'(1);
                2'b01:   r_mem_count <= r_mem_count - (LG_DEPTH+1)'(1);
                default: r_mem_count <= r_mem_count;
            endcase
        end
    end

    // Output stage: EMPTY fills on fetch, FULL empties on pop without refill.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: if (w_fetch) r_state <= S_FULL;
                S_FULL:  if (w_pop && !w_fetch) r_state <= S_EMPTY;
                default: r_state <= S_EMPTY;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_ram_ctrl
// Purpose  : Directed and stall-pattern bench for fifo_ram_ctrl with a
//            behavioural dual-port RAM and a queue reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_fifo_ram_ctrl;

    localparam int WIDTH    = 8;
    localparam int DEPTH    = 64;
    localparam int LG_DEPTH = 6;

    logic                clk;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [WIDTH-1:0]    in_data;
    logic                out_valid;
    logic                out_ready;
    logic [WIDTH-1:0]    out_data;
    logic                ram_ena;
    logic                ram_wea;
    logic [LG_DEPTH-1:0] ram_addra;
    logic [WIDTH-1:0]    ram_dina;
    logic                ram_enb;
    logic                ram_web;
    logic [LG_DEPTH-1:0] ram_addrb;
    logic [WIDTH-1:0]    ram_doutb;
    logic [LG_DEPTH:0]   count;

    int n_total = 0;
    int n_bad   = 0;
    logic [WIDTH-1:0] q_model[$];
    logic [WIDTH-1:0] ram_mem [DEPTH];

    fifo_ram_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LG_DEPTH(LG_DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .ram_ena   (ram_ena),
        .ram_wea   (ram_wea),
        .ram_addra (ram_addra),
        .ram_dina  (ram_dina),
        .ram_enb   (ram_enb),
        .ram_web   (ram_web),
        .ram_addrb (ram_addrb),
        .ram_doutb (ram_doutb),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: write on port A, registered read on port B.
    always @(posedge clk) begin
        if (ram_ena && ram_wea) ram_mem[ram_addra] <= ram_dina;
        if (ram_enb) ram_doutb <= ram_mem[ram_addrb];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // One clock: apply inputs, update the model from the handshakes, step.
    task automatic cycle(input logic iv, input logic [WIDTH-1:0] d, input logic ordy);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        #1;
        if (ram_ena && ram_enb && (ram_addra == ram_addrb))
            check("addr_collision", 32'(ram_addra), ~32'(ram_addrb));
        if (out_valid && out_ready) begin
            if (q_model.size() == 0) check("pop_underflow", 1, 0);
            else check("pop_data", 32'(out_data), 32'(q_model.pop_front()));
        end
        if (in_valid && in_ready) q_model.push_back(in_data);
        @(posedge clk);
        #1;
        check("count", 32'(count), 32'(q_model.size()));
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        q_model.delete();
    endtask

    task automatic drain(input string tag);
        int k = 0;
        while (q_model.size() != 0 && k < 300) begin
            cycle(1'b0, '0, 1'b1);
            k++;
        end
        check(tag, 32'(q_model.size()), 0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;

        // Reset state and single-word latency
        do_reset();
        check("rst_count", 32'(count), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("ram_web", 32'(ram_web), 0);
        cycle(1'b1, 8'h11, 1'b0);
        check("lat_edge1_valid", 32'(out_valid), 0);
        cycle(1'b0, 8'h00, 1'b0);
        check("lat_edge2_valid", 32'(out_valid), 1);
        check("lat_edge2_data", 32'(out_data), 32'h11);
        check("lat_edge2_count", 32'(count), 1);

        // Fill to DEPTH+1, then offer one more word
        do_reset();
        for (int i = 0; i <= DEPTH; i++) cycle(1'b1, 8'(i), 1'b0);
        check("full_count", 32'(count), 65);
        check("full_in_ready", 32'(in_ready), 0);
        cycle(1'b1, 8'h99, 1'b0);
        check("full_refuse_count", 32'(count), 65);
        check("full_head", 32'(out_data), 0);

        // Single pop from full
        cycle(1'b0, 8'h00, 1'b1);
        check("pop_in_ready", 32'(in_ready), 1);
        check("pop_next_data", 32'(out_data), 1);
        check("pop_count", 32'(count), 64);
        drain("drain_full");

        // Continuous stream: one word per cycle after two-cycle fill
        do_reset();
        for (int i = 0; i < 200; i++) begin
            if (i >= 2) check("stream_valid", 32'(out_valid), 1);
            cycle(1'b1, 8'(i), 1'b1);
        end
        check("stream_count", 32'(count), 2);
        drain("drain_stream");

        // Random stall patterns
        do_reset();
        for (int i = 0; i < 10000; i++)
            cycle(1'(($urandom_range(0, 3)) != 0), 8'($urandom), 1'($urandom_range(0, 1)));
        drain("drain_random");

        // Reset mid-stream with 30 words held
        do_reset();
        for (int i = 0; i < 30; i++) cycle(1'b1, 8'(i + 100), 1'b0);
        check("pre_rst_count", 32'(count), 30);
        rst = 1'b1; in_valid = 1'b1; in_data = 8'h77; out_ready = 1'b1;
        #1;
        check("rst_ram_ena", 32'(ram_ena), 0);
        check("rst_ram_enb", 32'(ram_enb), 0);
        @(posedge clk); #1;
        check("midrst_count", 32'(count), 0);
        check("midrst_out_valid", 32'(out_valid), 0);
        check("midrst_in_ready", 32'(in_ready), 1);
        rst = 1'b0;
        q_model.delete();
        cycle(1'b1, 8'hA5, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        check("after_rst_valid", 32'(out_valid), 1);
        check("after_rst_first", 32'(out_data), 32'hA5);
        drain("drain_after_rst");
        check("final_count", 32'(count), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_ram_ctrl.md
FIFO_RAM_CTRL -- requirements
Module: fifo_ram_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 64: RAM entries; DEPTH SHALL equal 2**LG_DEPTH.
REQ-003 SHALL have parameter LG_DEPTH, default 6: RAM address width.
REQ-004 SHALL have port clk, input, 1: single clock for all logic; the attached dual-port RAM runs both ports on it.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1: upstream word offered.
REQ-007 SHALL have port in_ready, output, 1: controller can accept a word.
REQ-008 SHALL have port in_data, input, WIDTH: upstream word.
REQ-009 SHALL have port out_valid, output, 1: out_data holds the oldest word.
REQ-010 SHALL have port out_ready, input, 1: downstream consumes the word.
REQ-011 SHALL have port out_data, output, WIDTH: oldest word.
REQ-012 SHALL have ports ram_ena, ram_wea, output, 1 each: RAM port A enable and write enable.
REQ-013 SHALL have port ram_addra, output, LG_DEPTH: RAM port A address.
REQ-014 SHALL have port ram_dina, output, WIDTH: RAM port A write data.
REQ-015 SHALL have ports ram_enb, ram_web, output, 1 each: RAM port B enable and write enable.
REQ-016 SHALL have port ram_addrb, output, LG_DEPTH: RAM port B address.
REQ-017 SHALL have port ram_doutb, input, WIDTH: RAM port B registered read data (1-cycle latency, held while ram_enb=0).
REQ-018 SHALL have port count, output, LG_DEPTH+1: total words held (RAM plus output stage).

Function
REQ-019 SHALL keep wr_ptr, rd_ptr (LG_DEPTH bits, wrap DEPTH-1 -> 0), mem_count (0..DEPTH) and out_valid.
REQ-020 SHALL drive in_ready = (mem_count < DEPTH), combinationally from registered state only.
REQ-021 SHALL define push = in_valid && in_ready; ram_ena = ram_wea = push; ram_addra = wr_ptr; ram_dina = in_data.
REQ-022 SHALL use port A for writes only and port B for reads only; ram_web SHALL be constant 0.
REQ-023 SHALL define pop = out_valid && out_ready.
REQ-024 SHALL define fetch = (mem_count != 0) && (!out_valid || out_ready); ram_enb = fetch; ram_addrb = rd_ptr.
REQ-025 SHALL on push advance wr_ptr by 1; on fetch advance rd_ptr by 1.
REQ-026 SHALL update mem_count by +1 on push only, -1 on fetch only, unchanged on both or neither.
REQ-027 SHALL implement output stage with states EMPTY (out_valid=0) and FULL (out_valid=1): EMPTY->FULL on fetch; FULL->EMPTY on pop without fetch; FULL->FULL on fetch (with or without pop).
REQ-028 SHALL drive out_data = ram_doutb directly; no word is lost because ram_enb is asserted only when the stage is empty or being popped.
REQ-029 SHALL give latency: word pushed at edge t into an empty controller shows out_valid=1 after edge t+2.
REQ-030 SHALL sustain one push and one pop per cycle at steady state.
REQ-031 SHALL drive count = mem_count + out_valid, range 0..DEPTH+1.
REQ-032 SHALL ignore in_data when push=0 and SHALL never fetch when mem_count=0 (empty underflow impossible).
REQ-033 SHALL hold all state when in_valid=0 and the output stage is FULL with out_ready=0.
REQ-034 SHALL, with mem_count=DEPTH, keep in_ready=0 until a fetch occurs; in_ready rises after that edge.
REQ-035 SHALL never address the same RAM location for write and read in one cycle (write slot always outside the occupied range).

Reset
REQ-036 SHALL on rst=1 at a clk edge set wr_ptr=0, rd_ptr=0, mem_count=0, out_valid=0, regardless of in-flight push/fetch; rst dominates.
REQ-037 SHALL during rst=1 drive in_ready=1 after the first reset edge and ram_ena=ram_enb=0 only through push/fetch being 0-gated by rst.
REQ-038 SHALL not clear RAM contents; stale data is unreachable after reset.

Verification
REQ-039 Reset then push 0x11 with out_ready=0 -> out_valid=1 two edges later, out_data=0x11, count=1.
REQ-040 Push DEPTH+1 words (0..64) with out_ready=0 -> count=65, in_ready=0, 66th word refused.
REQ-041 From full, assert out_ready=1 for one cycle -> word 0 popped, in_ready=1 next cycle, next out_data=1.
REQ-042 Stream 200 words with in_valid=out_ready=1 -> in-order output, 1 word/cycle after 2-cycle fill, pointers wrap cleanly.
REQ-043 Random in_valid/out_ready stall patterns over 10000 cycles -> scoreboard order match, count matches model.
REQ-044 Assert rst with count=30 mid-stream -> next cycle count=0, out_valid=0; following push 0xA5 emerges first.
